// File: rtl/fibre_a_arbiter.sv
// Round-robin arbiter sharing one fibre_a SRAM read port among NUM_PE requesters.
// Each PE holds at most one pending read; returned words are steered back by tag.
module fibre_a_arbiter #(
    parameter int NUM_PE     = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMESTEPS  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PE*ADDR_WIDTH-1:0]    pe_addr_i,
    input  logic [NUM_PE-1:0]               pe_read_en_i,
    output logic [NUM_PE*TIMESTEPS-1:0]     pe_data_o,
    output logic [NUM_PE-1:0]               pe_valid_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic                            mem_rd_en_o,
    input  logic [TIMESTEPS-1:0]            mem_rd_data_i,
    input  logic                            mem_stall_i,
    output logic                            busy_o,
    output logic [NUM_PE-1:0]               overrun_err_o
);

    localparam int PTR_W = $clog2(NUM_PE);

    logic [NUM_PE-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]  addr_q [NUM_PE];
    logic [ADDR_WIDTH-1:0]  addr_d [NUM_PE];
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    // Stage 0 is loaded with the grant; stage RD_LATENCY lines up with mem_rd_data_i.
    logic [RD_LATENCY:0]    tag_vld_q, tag_vld_d;
    logic [PTR_W-1:0]       tag_id_q [RD_LATENCY+1];
    logic [PTR_W-1:0]       tag_id_d [RD_LATENCY+1];
    logic [TIMESTEPS-1:0]   data_q [NUM_PE];
    logic [TIMESTEPS-1:0]   data_d [NUM_PE];
    logic [NUM_PE-1:0]      pe_valid_q, pe_valid_d;
    logic [NUM_PE-1:0]      overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic                   found;
    logic [PTR_W-1:0]       win;
    logic [PTR_W-1:0]       cand;
    logic [NUM_PE-1:0]      grant_vec;
    int                     idx;

    always_comb begin
        pending_d   = pending_q;
        addr_d      = addr_q;
        rr_d        = rr_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        data_d      = data_q;
        pe_valid_d  = '0;
        overrun_d   = overrun_q;
        grant_vec   = '0;
        found       = 1'b0;
        win         = '0;
        cand        = '0;
        idx         = 0;

        for (int k = 0; k < NUM_PE; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_PE) idx = idx - NUM_PE;
            cand = PTR_W'(idx);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        if (!mem_stall_i && found) begin
            mem_rd_en_d    = 1'b1;
            mem_addr_d     = addr_q[win];
            grant_vec[win] = 1'b1;
            rr_d           = (win == PTR_W'(NUM_PE - 1)) ? '0 : win + 1'b1;
        end

        tag_vld_d   = {tag_vld_q[RD_LATENCY-1:0], mem_rd_en_d};
        tag_id_d[0] = win;
        for (int k = 1; k <= RD_LATENCY; k++) tag_id_d[k] = tag_id_q[k-1];

        if (tag_vld_q[RD_LATENCY]) begin
            pe_valid_d[tag_id_q[RD_LATENCY]] = 1'b1;
            data_d[tag_id_q[RD_LATENCY]]     = mem_rd_data_i;
        end

        // A PE being granted this edge may re-request without overrunning.
        pending_d = pending_q & ~grant_vec;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_read_en_i[i]) begin
                if (pending_d[i]) begin
                    overrun_d[i] = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    addr_d[i]    = pe_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end

        busy_d = (|pending_d) | (|tag_vld_d) | (|pe_valid_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            rr_q        <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            tag_vld_q   <= '0;
            pe_valid_q  <= '0;
            overrun_q   <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            for (int k = 0; k <= RD_LATENCY; k++) tag_id_q[k] <= '0;
        end else begin
            pending_q   <= pending_d;
            rr_q        <= rr_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            tag_vld_q   <= tag_vld_d;
            pe_valid_q  <= pe_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tag_id_q    <= tag_id_d;
        end
    end

    always_comb begin
        pe_data_o = '0;
        for (int i = 0; i < NUM_PE; i++) pe_data_o[i*TIMESTEPS +: TIMESTEPS] = data_q[i];
    end

    assign pe_valid_o    = pe_valid_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_rd_en_o   = mem_rd_en_q;
    assign busy_o        = busy_q;
    assign overrun_err_o = overrun_q;

endmodule
